// File: rtl/ppu_reg_port.sv
`default_nettype none
// ============================================================================
// Module   : ppu_reg_port
// Purpose  : CPU-facing PPU register file with VRAM access FSM, palette and OAM.
// Revision : 1.0 - initial release
// ============================================================================
module ppu_reg_port #(
    parameter int ADDR_W        = 14,
    parameter int PALETTE_DEPTH = 32,
    parameter int OAM_DEPTH     = 256,
    parameter int ACCESS_CYCLES = 2
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_cs_n,
    input  logic              i_rw,
    input  logic [2:0]        i_rs,
    input  logic [7:0]        i_data,
    output logic [7:0]        o_data,
    output logic              o_int_n,
    input  logic              i_vblank_start,
    input  logic              i_vblank_end,
    output logic              o_video_rd_n,
    output logic              o_video_we_n,
    output logic [ADDR_W-1:0] o_video_address,
    output logic [7:0]        o_video_data,
    input  logic [7:0]        i_video_data,
    output logic              o_busy,
    output logic [7:0]        o_ppuctrl,
    output logic [7:0]        o_ppumask,
    output logic [7:0]        o_scroll_x,
    output logic [7:0]        o_scroll_y,
    output logic              o_w
);
    localparam int c_pidx_w = (PALETTE_DEPTH > 1) ? $clog2(PALETTE_DEPTH) : 1;
    localparam int c_oam_w  = (OAM_DEPTH > 1) ? $clog2(OAM_DEPTH) : 1;
    localparam int c_cnt_w  = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(ACCESS_CYCLES - 1);
    localparam logic [ADDR_W-1:0]  c_inc_col  = ADDR_W'(32);
    localparam logic [ADDR_W-1:0]  c_inc_row  = ADDR_W'(1);
    localparam logic [2:0] c_rs_ctrl    = 3'd0;
    localparam logic [2:0] c_rs_mask    = 3'd1;
    localparam logic [2:0] c_rs_status  = 3'd2;
    localparam logic [2:0] c_rs_oamaddr = 3'd3;
    localparam logic [2:0] c_rs_oamdata = 3'd4;
    localparam logic [2:0] c_rs_scroll  = 3'd5;
    localparam logic [2:0] c_rs_addr    = 3'd6;
    localparam logic [2:0] c_rs_data    = 3'd7;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RD = 2'd1, S_WR = 2'd2} state_t;

    state_t              state_q, state_d;
    logic [7:0]          ctrl_q, ctrl_d, mask_q, mask_d;
    logic [7:0]          scroll_x_q, scroll_x_d, scroll_y_q, scroll_y_d;
    logic [7:0]          buffer_q, buffer_d, video_data_q, video_data_d;
    logic [ADDR_W-1:0]   vaddr_q, vaddr_d, video_address_q, video_address_d;
    logic [c_oam_w-1:0]  oamaddr_q, oamaddr_d;
    logic [c_cnt_w-1:0]  cnt_q, cnt_d;
    logic                toggle_q, toggle_d, flag_q, flag_d;
    logic                rd_n_q, rd_n_d, we_n_q, we_n_d;

    logic [7:0] palette_mem [PALETTE_DEPTH];
    logic [7:0] oam_mem [OAM_DEPTH];

    logic                w_rd, w_wr, w_busy, w_pal_win, w_data_go, w_pal_we, w_oam_we;
    logic [c_pidx_w-1:0] w_pidx;

    assign w_rd      = !i_cs_n && i_rw;
    assign w_wr      = !i_cs_n && !i_rw;
    assign w_busy    = (state_q != S_IDLE);
    assign w_pal_win = &vaddr_q[ADDR_W-1:8];
    assign w_data_go = !i_cs_n && (i_rs == c_rs_data) && !w_busy;
    assign w_pal_we  = w_data_go && !i_rw && w_pal_win;
    assign w_oam_we  = w_wr && (i_rs == c_rs_oamdata);

    // Backdrop entries of the sprite palettes alias onto the background ones.
    generate
        if (PALETTE_DEPTH == 32) begin : g_pal_mirror
            assign w_pidx = (vaddr_q[1:0] == 2'b00) ? {1'b0, vaddr_q[3:0]} : vaddr_q[4:0];
        end else begin : g_pal_direct
            assign w_pidx = vaddr_q[c_pidx_w-1:0];
        end
    endgenerate

    always_comb begin
        o_data = 8'h00;
        if (w_rd) begin
            case (i_rs)
                c_rs_status:  o_data = {flag_q & ~i_vblank_start, 7'b0};
                c_rs_oamdata: o_data = oam_mem[oamaddr_q];
                c_rs_data:    o_data = (w_data_go && w_pal_win) ? palette_mem[w_pidx] : buffer_q;
                default:      o_data = 8'h00;
            endcase
        end
    end

    always_comb begin
        state_d         = state_q;
        ctrl_d          = ctrl_q;
        mask_d          = mask_q;
        scroll_x_d      = scroll_x_q;
        scroll_y_d      = scroll_y_q;
        buffer_d        = buffer_q;
        video_data_d    = video_data_q;
        vaddr_d         = vaddr_q;
        video_address_d = video_address_q;
        oamaddr_d       = oamaddr_q;
        cnt_d           = cnt_q;
        toggle_d        = toggle_q;
        flag_d          = flag_q;
        rd_n_d          = rd_n_q;
        we_n_d          = we_n_q;

        if (w_rd && (i_rs == c_rs_status)) begin
            flag_d   = 1'b0;
            toggle_d = 1'b0;
        end else if (i_vblank_start) begin
            flag_d = 1'b1;
        end else if (i_vblank_end) begin
            flag_d = 1'b0;
        end

        if (w_wr) begin
            case (i_rs)
                c_rs_ctrl:    ctrl_d = i_data;
                c_rs_mask:    mask_d = i_data;
                c_rs_oamaddr: oamaddr_d = c_oam_w'(i_data);
                c_rs_oamdata: oamaddr_d = oamaddr_q + c_oam_w'(1);
                c_rs_scroll: begin
                    if (toggle_q) scroll_y_d = i_data;
                    else          scroll_x_d = i_data;
                    toggle_d = ~toggle_q;
                end
                c_rs_addr: begin
                    if (toggle_q) vaddr_d[7:0]        = i_data;
                    else          vaddr_d[ADDR_W-1:8] = i_data[ADDR_W-9:0];
                    toggle_d = ~toggle_q;
                end
                default: ;
            endcase
        end

        if (w_data_go) vaddr_d = vaddr_q + (ctrl_q[2] ? c_inc_col : c_inc_row);

        case (state_q)
            S_IDLE: begin
                if (w_data_go && (i_rw || !w_pal_win)) begin
                    video_address_d = vaddr_q;
                    cnt_d           = c_cnt_last;
                    if (i_rw) begin
                        state_d = S_RD;
                        rd_n_d  = 1'b0;
                    end else begin
                        state_d      = S_WR;
                        we_n_d       = 1'b0;
                        video_data_d = i_data;
                    end
                end
            end
            S_RD: begin
                if (cnt_q == '0) begin
                    buffer_d = i_video_data;
                    rd_n_d   = 1'b1;
                    state_d  = S_IDLE;
                end else begin
                    cnt_d = cnt_q - c_cnt_w'(1);
                end
            end
            S_WR: begin
                if (cnt_q == '0) begin
                    we_n_d       = 1'b1;
                    video_data_d = 8'h00;
                    state_d      = S_IDLE;
                end else begin
                    cnt_d = cnt_q - c_cnt_w'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(negedge i_clk) begin
        if (!i_reset_n) begin
            state_q         <= S_IDLE;
            ctrl_q          <= 8'h00;
            mask_q          <= 8'h00;
            scroll_x_q      <= 8'h00;
            scroll_y_q      <= 8'h00;
            buffer_q        <= 8'h00;
            video_data_q    <= 8'h00;
            vaddr_q         <= '0;
            video_address_q <= '0;
            oamaddr_q       <= '0;
            cnt_q           <= '0;
            toggle_q        <= 1'b0;
            flag_q          <= 1'b0;
            rd_n_q          <= 1'b1;
            we_n_q          <= 1'b1;
        end else begin
            state_q         <= state_d;
            ctrl_q          <= ctrl_d;
            mask_q          <= mask_d;
            scroll_x_q      <= scroll_x_d;
            scroll_y_q      <= scroll_y_d;
            buffer_q        <= buffer_d;
            video_data_q    <= video_data_d;
            vaddr_q         <= vaddr_d;
            video_address_q <= video_address_d;
            oamaddr_q       <= oamaddr_d;
            cnt_q           <= cnt_d;
            toggle_q        <= toggle_d;
            flag_q          <= flag_d;
            rd_n_q          <= rd_n_d;
            we_n_q          <= we_n_d;
        end
    end

    always_ff @(negedge i_clk) begin
        if (i_reset_n && w_pal_we) palette_mem[w_pidx] <= i_data;
        if (i_reset_n && w_oam_we) oam_mem[oamaddr_q] <= i_data;
    end

    assign o_int_n         = ~(flag_q & ctrl_q[7]);
    assign o_video_rd_n    = rd_n_q;
    assign o_video_we_n    = we_n_q;
    assign o_video_address = video_address_q;
    assign o_video_data    = video_data_q;
    assign o_busy          = w_busy;
    assign o_ppuctrl       = ctrl_q;
    assign o_ppumask       = mask_q;
    assign o_scroll_x      = scroll_x_q;
    assign o_scroll_y      = scroll_y_q;
    assign o_w             = toggle_q;
endmodule
`default_nettype wire

// File: tb/tb_ppu_reg_port.sv
`default_nettype none
// ============================================================================
// Module   : tb_ppu_reg_port
// Purpose  : Directed scenarios plus randomized traffic against a reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ppu_reg_port;
    localparam int ADDR_W        = 14;
    localparam int PALETTE_DEPTH = 32;
    localparam int OAM_DEPTH     = 256;
    localparam int ACCESS_CYCLES = 2;
    localparam int VSIZE         = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              reset_n, cs_n, rw, vs, ve;
    logic [2:0]        rs;
    logic [7:0]        wdata;
    logic [7:0]        rdata, vdata_out, vdata_in, ppuctrl, ppumask, sx, sy;
    logic              int_n, rd_n, we_n, busy, w;
    logic [ADDR_W-1:0] vaddr_out;
    logic [7:0]        vram [VSIZE];

    assign vdata_in = vram[vaddr_out];

    ppu_reg_port #(.ADDR_W(ADDR_W), .PALETTE_DEPTH(PALETTE_DEPTH),
                   .OAM_DEPTH(OAM_DEPTH), .ACCESS_CYCLES(ACCESS_CYCLES)) u_dut (
        .i_clk(clk), .i_reset_n(reset_n), .i_cs_n(cs_n), .i_rw(rw), .i_rs(rs),
        .i_data(wdata), .o_data(rdata), .o_int_n(int_n),
        .i_vblank_start(vs), .i_vblank_end(ve),
        .o_video_rd_n(rd_n), .o_video_we_n(we_n), .o_video_address(vaddr_out),
        .o_video_data(vdata_out), .i_video_data(vdata_in), .o_busy(busy),
        .o_ppuctrl(ppuctrl), .o_ppumask(ppumask), .o_scroll_x(sx), .o_scroll_y(sy),
        .o_w(w)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [7:0] m_ctrl, m_mask, m_sx, m_sy, m_buf, m_wd;
    int         m_vaddr, m_oamaddr, m_busy, m_addr;
    bit         m_w, m_flag, m_rd;
    logic [7:0] m_pal [PALETTE_DEPTH];
    bit         m_pal_known [PALETTE_DEPTH];
    logic [7:0] m_oam [OAM_DEPTH];
    bit         m_oam_known [OAM_DEPTH];

    // Inputs change just after the rising edge; the DUT acts on the falling edge.
    task automatic cyc_begin(input logic c, input logic r, input logic [2:0] s,
                             input logic [7:0] d, input logic vst, input logic ven);
        @(posedge clk);
        cs_n = c; rw = r; rs = s; wdata = d; vs = vst; ve = ven;
        #2;
    endtask

    task automatic cyc_end();
        @(negedge clk);
        #1;
    endtask

    task automatic wr_reg(input logic [2:0] s, input logic [7:0] d);
        cyc_begin(1'b0, 1'b0, s, d, 1'b0, 1'b0);
        cyc_end();
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            cyc_begin(1'b1, 1'b1, 3'd0, 8'h00, 1'b0, 1'b0);
            cyc_end();
        end
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        idle(2);
        reset_n = 1'b1;
    endtask

    function automatic int pal_index(input int a);
        int i;
        i = a % PALETTE_DEPTH;
        if (PALETTE_DEPTH == 32 && i >= 16 && (i % 4) == 0) i -= 16;
        return i;
    endfunction

    function automatic bit in_pal(input int a);
        return (a >> 8) == (VSIZE / 256 - 1);
    endfunction

    task automatic test_reset();
        apply_reset();
        wr_reg(3'd0, 8'h84); wr_reg(3'd1, 8'h1E); wr_reg(3'd5, 8'h33);
        wr_reg(3'd6, 8'h21); wr_reg(3'd7, 8'h42);
        cyc_begin(1'b1, 1'b1, 3'd0, 8'h00, 1'b1, 1'b0); cyc_end();
        apply_reset();
        checks++; if ({busy, rd_n, we_n, int_n, w} !== 5'b01110) begin errors++;
            $display("FAIL reset_ctl: got %b want 01110", {busy, rd_n, we_n, int_n, w}); end
        checks++; if (vaddr_out !== '0 || vdata_out !== 8'h00) begin errors++;
            $display("FAIL reset_vid: got %h/%h want 0000/00", vaddr_out, vdata_out); end
        checks++; if ({ppuctrl, ppumask, sx, sy} !== 32'h0) begin errors++;
            $display("FAIL reset_regs: got %h want 00000000", {ppuctrl, ppumask, sx, sy}); end
        cyc_begin(1'b0, 1'b1, 3'd2, 8'h00, 1'b0, 1'b0);
        checks++; if (rdata !== 8'h00) begin errors++;
            $display("FAIL reset_status: got %h want 00", rdata); end
        cyc_end();
    endtask

    task automatic test_vram_write();
        apply_reset();
        wr_reg(3'd6, 8'h21); wr_reg(3'd6, 8'h08); wr_reg(3'd7, 8'h5A);
        checks++; if ({we_n, rd_n, busy} !== 3'b011 || vaddr_out !== 14'h2108 || vdata_out !== 8'h5A) begin
            errors++; $display("FAIL vwr_start: got %b %h %h want 011 2108 5a", {we_n, rd_n, busy}, vaddr_out, vdata_out); end
        idle(1);
        checks++; if (we_n !== 1'b0 || vdata_out !== 8'h5A) begin errors++;
            $display("FAIL vwr_hold: got %b %h want 0 5a", we_n, vdata_out); end
        idle(1);
        checks++; if ({we_n, busy} !== 2'b10 || vdata_out !== 8'h00) begin errors++;
            $display("FAIL vwr_end: got %b %h want 10 00", {we_n, busy}, vdata_out); end
        cyc_begin(1'b0, 1'b1, 3'd7, 8'h00, 1'b0, 1'b0); cyc_end();
        checks++; if (vaddr_out !== 14'h2109 || rd_n !== 1'b0) begin errors++;
            $display("FAIL vwr_incr: got %h %b want 2109 0", vaddr_out, rd_n); end
        idle(2);
    endtask

    task automatic test_vram_read();
        apply_reset();
        vram[14'h2000] = 8'h11; vram[14'h2020] = 8'h99;
        wr_reg(3'd0, 8'h04); wr_reg(3'd6, 8'h20); wr_reg(3'd6, 8'h00);
        cyc_begin(1'b0, 1'b1, 3'd7, 8'h00, 1'b0, 1'b0);
        checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL vrd_stale: got %h want 00", rdata); end
        cyc_end();
        checks++; if (rd_n !== 1'b0 || vaddr_out !== 14'h2000) begin errors++;
            $display("FAIL vrd_strobe: got %b %h want 0 2000", rd_n, vaddr_out); end
        idle(2);
        cyc_begin(1'b0, 1'b1, 3'd7, 8'h00, 1'b0, 1'b0);
        checks++; if (rdata !== 8'h11) begin errors++; $display("FAIL vrd_buf: got %h want 11", rdata); end
        cyc_end();
        checks++; if (vaddr_out !== 14'h2020) begin errors++; $display("FAIL vrd_inc32: got %h want 2020", vaddr_out); end
        idle(2);
        cyc_begin(1'b0, 1'b1, 3'd7, 8'h00, 1'b0, 1'b0);
        checks++; if (rdata !== 8'h99) begin errors++; $display("FAIL vrd_buf2: got %h want 99", rdata); end
        cyc_end();
        checks++; if (vaddr_out !== 14'h2040) begin errors++; $display("FAIL vrd_vaddr: got %h want 2040", vaddr_out); end
        idle(2);
    endtask

    task automatic test_palette();
        apply_reset();
        wr_reg(3'd6, 8'h3F); wr_reg(3'd6, 8'h10); wr_reg(3'd7, 8'h2C);
        checks++; if ({rd_n, we_n, busy} !== 3'b110) begin errors++;
            $display("FAIL pal_nostrobe: got %b want 110", {rd_n, we_n, busy}); end
        wr_reg(3'd6, 8'h3F); wr_reg(3'd6, 8'h00);
        cyc_begin(1'b0, 1'b1, 3'd7, 8'h00, 1'b0, 1'b0);
        checks++; if (rdata !== 8'h2C) begin errors++; $display("FAIL pal_mirror: got %h want 2c", rdata); end
        cyc_end();
        checks++; if (rd_n !== 1'b0 || vaddr_out !== 14'h3F00) begin errors++;
            $display("FAIL pal_fetch: got %b %h want 0 3f00", rd_n, vaddr_out); end
        idle(2);
    endtask

    task automatic test_nmi();
        apply_reset();
        wr_reg(3'd0, 8'h80); wr_reg(3'd5, 8'h12);
        cyc_begin(1'b1, 1'b1, 3'd0, 8'h00, 1'b1, 1'b0); cyc_end();
        checks++; if (int_n !== 1'b0) begin errors++; $display("FAIL nmi_assert: got %b want 0", int_n); end
        cyc_begin(1'b0, 1'b1, 3'd2, 8'h00, 1'b0, 1'b0);
        checks++; if (rdata !== 8'h80) begin errors++; $display("FAIL nmi_status: got %h want 80", rdata); end
        cyc_end();
        checks++; if ({int_n, w} !== 2'b10) begin errors++; $display("FAIL nmi_clear: got %b want 10", {int_n, w}); end
        apply_reset();
        cyc_begin(1'b1, 1'b1, 3'd0, 8'h00, 1'b1, 1'b0); cyc_end();
        checks++; if (int_n !== 1'b1) begin errors++; $display("FAIL nmi_masked: got %b want 1", int_n); end
        wr_reg(3'd0, 8'h80);
        checks++; if (int_n !== 1'b0) begin errors++; $display("FAIL nmi_late_en: got %b want 0", int_n); end
        cyc_begin(1'b1, 1'b1, 3'd0, 8'h00, 1'b0, 1'b1); cyc_end();
        checks++; if (int_n !== 1'b1) begin errors++; $display("FAIL nmi_vend: got %b want 1", int_n); end
    endtask

    task automatic test_suppress();
        apply_reset();
        wr_reg(3'd0, 8'h80);
        cyc_begin(1'b0, 1'b1, 3'd2, 8'h00, 1'b1, 1'b0);
        checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL supp_read: got %h want 00", rdata); end
        cyc_end();
        checks++; if (int_n !== 1'b1) begin errors++; $display("FAIL supp_int: got %b want 1", int_n); end
        cyc_begin(1'b0, 1'b1, 3'd2, 8'h00, 1'b0, 1'b0);
        checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL supp_flag: got %h want 00", rdata); end
        cyc_end();
    endtask

    task automatic test_oam();
        apply_reset();
        wr_reg(3'd3, 8'hFF); wr_reg(3'd4, 8'hAA); wr_reg(3'd4, 8'hBB); wr_reg(3'd3, 8'hFF);
        for (int k = 0; k < 2; k++) begin
            cyc_begin(1'b0, 1'b1, 3'd4, 8'h00, 1'b0, 1'b0);
            checks++; if (rdata !== 8'hAA) begin errors++; $display("FAIL oam_ff rd%0d: got %h want aa", k, rdata); end
            cyc_end();
        end
        wr_reg(3'd3, 8'h00);
        cyc_begin(1'b0, 1'b1, 3'd4, 8'h00, 1'b0, 1'b0);
        checks++; if (rdata !== 8'hBB) begin errors++; $display("FAIL oam_wrap: got %h want bb", rdata); end
        cyc_end();
    endtask

    task automatic test_busy();
        apply_reset();
        wr_reg(3'd6, 8'h21); wr_reg(3'd6, 8'h00); wr_reg(3'd7, 8'h11);
        wr_reg(3'd7, 8'h22);
        checks++; if (we_n !== 1'b0 || vdata_out !== 8'h11 || vaddr_out !== 14'h2100) begin errors++;
            $display("FAIL busy_ignore: got %b %h %h want 0 11 2100", we_n, vdata_out, vaddr_out); end
        idle(1);
        wr_reg(3'd7, 8'h33);
        checks++; if (vaddr_out !== 14'h2101 || vdata_out !== 8'h33) begin errors++;
            $display("FAIL busy_noinc: got %h %h want 2101 33", vaddr_out, vdata_out); end
        wr_reg(3'd6, 8'h23);
        checks++; if (vaddr_out !== 14'h2101 || busy !== 1'b1) begin errors++;
            $display("FAIL busy_addr: got %h %b want 2101 1", vaddr_out, busy); end
        wr_reg(3'd6, 8'h45);
        cyc_begin(1'b0, 1'b1, 3'd7, 8'h00, 1'b0, 1'b0); cyc_end();
        checks++; if (vaddr_out !== 14'h2345) begin errors++; $display("FAIL busy_newaddr: got %h want 2345", vaddr_out); end
        idle(2);
    endtask

    task automatic test_abort();
        apply_reset();
        vram[14'h2000] = 8'h77;
        wr_reg(3'd6, 8'h20); wr_reg(3'd6, 8'h00);
        cyc_begin(1'b0, 1'b1, 3'd7, 8'h00, 1'b0, 1'b0); cyc_end();
        reset_n = 1'b0;
        idle(1);
        checks++; if ({rd_n, busy} !== 2'b10) begin errors++; $display("FAIL abort_strobe: got %b want 10", {rd_n, busy}); end
        reset_n = 1'b1;
        cyc_begin(1'b0, 1'b1, 3'd7, 8'h00, 1'b0, 1'b0);
        checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL abort_buf: got %h want 00", rdata); end
        cyc_end();
        idle(2);
    endtask

    task automatic test_random();
        logic       c, r, vst, ven, exp_known, is_rd, is_wr, was_busy;
        logic [2:0] s;
        logic [7:0] d, exp_d;
        int         k;
        apply_reset();
        m_ctrl = 0; m_mask = 0; m_sx = 0; m_sy = 0; m_buf = 0; m_wd = 0;
        m_vaddr = 0; m_oamaddr = 0; m_busy = 0; m_addr = 0; m_w = 0; m_flag = 0; m_rd = 0;
        for (int n = 0; n < 3000; n++) begin
            c = ($urandom_range(0, 5) == 0);
            r = 1'($urandom_range(0, 1));
            k = $urandom_range(0, 9);
            s = (k < 3) ? 3'd7 : (k < 5) ? 3'd6 : 3'($urandom_range(0, 7));
            d = 8'($urandom);
            if (s == 3'd6 && !m_w) begin
                k = $urandom_range(0, 2);
                d = (k == 0) ? 8'hFF : (k == 1) ? 8'h3F : d;
            end
            if (s == 3'd3) d = 8'($urandom_range(0, 7) - 4);
            vst = ($urandom_range(0, 19) == 0);
            ven = !vst && ($urandom_range(0, 19) == 0);
            cyc_begin(c, r, s, d, vst, ven);
            is_rd = !c && r;
            is_wr = !c && !r;
            exp_d = 8'h00;
            exp_known = 1'b1;
            if (is_rd) begin
                case (s)
                    3'd2: exp_d = {(m_flag && !vst), 7'b0};
                    3'd4: begin exp_d = m_oam[m_oamaddr]; exp_known = m_oam_known[m_oamaddr]; end
                    3'd7: begin
                        if (m_busy == 0 && in_pal(m_vaddr)) begin
                            exp_d = m_pal[pal_index(m_vaddr)];
                            exp_known = m_pal_known[pal_index(m_vaddr)];
                        end else exp_d = m_buf;
                    end
                    default: exp_d = 8'h00;
                endcase
            end
            if (exp_known) begin
                checks++; if (rdata !== exp_d) begin errors++;
                    $display("FAIL rand_rdata n=%0d rs=%0d: got %h want %h", n, s, rdata, exp_d); end
            end
            was_busy = (m_busy != 0);
            if (is_rd && s == 3'd2) begin m_flag = 0; m_w = 0; end
            else if (vst) m_flag = 1;
            else if (ven) m_flag = 0;
            if (is_wr) begin
                case (s)
                    3'd0: m_ctrl = d;
                    3'd1: m_mask = d;
                    3'd3: m_oamaddr = int'(d) % OAM_DEPTH;
                    3'd4: begin
                        m_oam[m_oamaddr] = d; m_oam_known[m_oamaddr] = 1;
                        m_oamaddr = (m_oamaddr + 1) % OAM_DEPTH;
                    end
                    3'd5: begin if (m_w) m_sy = d; else m_sx = d; m_w = !m_w; end
                    3'd6: begin
                        if (m_w) m_vaddr = (m_vaddr / 256) * 256 + int'(d);
                        else     m_vaddr = (int'(d) * 256 + m_vaddr % 256) % VSIZE;
                        m_w = !m_w;
                    end
                    default: ;
                endcase
            end
            if (was_busy) begin
                m_busy--;
                if (m_busy == 0 && m_rd) m_buf = vram[m_addr];
            end else if (!c && s == 3'd7) begin
                if (is_wr && in_pal(m_vaddr)) begin
                    m_pal[pal_index(m_vaddr)] = d;
                    m_pal_known[pal_index(m_vaddr)] = 1;
                end else begin
                    m_busy = ACCESS_CYCLES; m_rd = r; m_addr = m_vaddr; m_wd = d;
                end
                m_vaddr = (m_vaddr + (m_ctrl[2] ? 32 : 1)) % VSIZE;
            end
            cyc_end();
            checks++; if (busy !== (m_busy != 0)) begin errors++;
                $display("FAIL rand_busy n=%0d: got %b want %b", n, busy, (m_busy != 0)); end
            checks++; if ({rd_n, we_n} !== {!(m_busy != 0 && m_rd), !(m_busy != 0 && !m_rd)}) begin errors++;
                $display("FAIL rand_strobes n=%0d: got %b%b", n, rd_n, we_n); end
            checks++; if (vaddr_out !== ADDR_W'(m_addr)) begin errors++;
                $display("FAIL rand_vaddr n=%0d: got %h want %h", n, vaddr_out, ADDR_W'(m_addr)); end
            checks++; if (vdata_out !== ((m_busy != 0 && !m_rd) ? m_wd : 8'h00)) begin errors++;
                $display("FAIL rand_vdata n=%0d: got %h", n, vdata_out); end
            checks++; if (int_n !== !(m_flag && m_ctrl[7])) begin errors++;
                $display("FAIL rand_int n=%0d: got %b want %b", n, int_n, !(m_flag && m_ctrl[7])); end
            checks++; if ({ppuctrl, ppumask, sx, sy, w} !== {m_ctrl, m_mask, m_sx, m_sy, m_w}) begin errors++;
                $display("FAIL rand_regs n=%0d: got %h want %h", n, {ppuctrl, ppumask, sx, sy, w},
                         {m_ctrl, m_mask, m_sx, m_sy, m_w}); end
        end
    endtask

    initial begin
        reset_n = 1'b0; cs_n = 1'b1; rw = 1'b1; rs = 3'd0; wdata = 8'h00; vs = 1'b0; ve = 1'b0;
        for (int i = 0; i < VSIZE; i++) vram[i] = 8'($urandom);
        for (int i = 0; i < PALETTE_DEPTH; i++) begin m_pal[i] = 8'h00; m_pal_known[i] = 0; end
        for (int i = 0; i < OAM_DEPTH; i++) begin m_oam[i] = 8'h00; m_oam_known[i] = 0; end
        test_reset();
        test_vram_write();
        test_vram_read();
        test_palette();
        test_nmi();
        test_suppress();
        test_oam();
        test_busy();
        test_abort();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
